gate_tt_tester: RTL
===================

// Module: gate_tt_tester
// PURPOSE
//  Sequential truth-table exerciser: the driving/reading end of a combinational gate's a,b -> y interface.
//  Walks every input vector, waits a settle time, samples the gate output, compares against EXP_TT.
//  Reports pass/fail, error count, first failing vector. Sits beside any gate (and/or/xor...) for on-chip self-check.
// PARAMETERS
//  N_IN        2         number of gate inputs; vectors 0 .. 2**N_IN-1
//  SETTLE_CYC  1         cycles vec_out held before sampling; legal range >=1
//  EXP_TT      4'b1000   expected output, bit[v] = y for vector v (default = AND); width 2**N_IN
// PORTS
//  clk            in   1              rising-edge clock
//  rst_n          in   1              synchronous reset, active low
//  start          in   1              pulse: begin a sweep (honoured only in IDLE)
//  vec_out        out  N_IN           drives gate inputs; vec_out[0] = a, vec_out[1] = b
//  y_in           in   1              gate output under test
//  busy           out  1              high from the cycle after start until done
//  done           out  1              one-cycle pulse at end of sweep
//  pass           out  1              registered; 1 = zero mismatches; valid from done until next start
//  err_cnt        out  N_IN+1         mismatch count for the last sweep
//  first_err_vec  out  N_IN           first mismatching vector; 0 if none
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; vec_out, err_cnt, first_err_vec = 0; busy, done, pass = 0.
//  Reset mid-sweep aborts immediately, with no done pulse.
//  FSM IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  IDLE:   start=1 -> DRIVE; vec_out=0, settle cnt=0, err_cnt=0, first_err_vec=0, pass=0.
//  DRIVE:  hold vec_out for SETTLE_CYC cycles (cnt 0..SETTLE_CYC-1), then -> SAMPLE.
//  SAMPLE: one cycle; compare y_in to EXP_TT[vec_out] at the end of the cycle.
//          On mismatch: err_cnt+1; if err_cnt==0 beforehand, first_err_vec=vec_out.
//          If vec_out == 2**N_IN-1 -> DONE; else vec_out+1 -> DRIVE, cnt=0.
//  DONE:   done=1 for exactly one cycle; pass=(final err_cnt==0), including a mismatch on the last vector; -> IDLE.
//  busy=1 in DRIVE/SAMPLE/DONE-entry, 0 in the cycle done is high.
//  Per-vector latency: SETTLE_CYC+1 cycles.
//  done is high in cycle 2**N_IN*(SETTLE_CYC+1)+1 after the start edge (N_IN=2, SETTLE_CYC=1 -> cycle 9).
//  start while not IDLE: ignored, no restart.
//  start in the same cycle as done: ignored; a new start is accepted from IDLE the next cycle.
//  vec_out holds its last value (2**N_IN-1) after DONE until the next start or reset.
//  err_cnt cannot overflow (max 2**N_IN, width N_IN+1).
//  Results persist in IDLE until the next start.
// CONFIGURATION
//  `GATE_TT_CAPTURE_EN defined: extra port observed_tt out 2**N_IN.
//    observed_tt[v] = y_in sampled for vector v; cleared to 0 on reset and on start; complete at done.
//  Macro undefined: the port and its register do not exist; all other behaviour is identical.
// STRUCTURE
//  Package gate_tt_pkg:
//    - state enum (IDLE, DRIVE, SAMPLE, DONE)
//    - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111
//  One sub-module: gate_tt_settle_cnt (load/count/expire counter for SETTLE_CYC); FSM and scoreboard stay in top.
// TESTING
//  1 AND gate on vec_out/y_in, EXP_TT=TT_AND, start pulse
//    -> done in cycle 9, pass=1, err_cnt=0, first_err_vec=0.
//  2 y_in tied 0, EXP_TT=TT_AND
//    -> err_cnt=1, first_err_vec=2'b11, pass=0.
//  3 OR gate connected, EXP_TT=TT_AND
//    -> err_cnt=2, first_err_vec=2'b01; with macro, observed_tt=4'b1110.
//  4 start pulsed again at cycles 3 and 5 of a sweep
//    -> ignored; a single done at cycle 9.
//  5 rst_n=0 at cycle 4 of a sweep
//    -> next cycle: busy=0, vec_out=0, err_cnt=0, no done; a fresh start completes normally.
//  6 SETTLE_CYC=3, XOR gate, EXP_TT=TT_XOR
//    -> done in cycle 17, pass=1; vec_out stable 3 cycles per vector.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table tester.
// Optional feature macro used by gate_tt_tester: GATE_TT_CAPTURE_EN.
package gate_tt_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Expected truth tables for two-input gates, bit[v] = y for vector v = {b,a}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Counter width able to hold 0 .. n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// Settle-time counter: cleared by load, counts while enabled, flags the last settle cycle.
module gate_tt_settle_cnt
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = cnt_width(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Expiry is the final hold cycle, so the controller leaves DRIVE after SETTLE_CYC cycles
  assign expire_c = en && (cnt_q == CNT_LAST);

  // Count register: restarts on load, saturates at the last settle cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gate_tt_tester.sv
// Truth-table exerciser: sweeps all gate input vectors, samples y_in after a settle
// time and scores it against EXP_TT. Define GATE_TT_CAPTURE_EN to add the
// observed_tt port recording the sampled output for every vector.
module gate_tt_tester
  import gate_tt_pkg::*;
#(
  parameter int unsigned            N_IN       = 2,
  parameter int unsigned            SETTLE_CYC = 1,
  parameter logic [2**N_IN-1:0]     EXP_TT     = TT_AND
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_err_vec
`ifdef GATE_TT_CAPTURE_EN
  ,
  output logic [2**N_IN-1:0] observed_tt
`endif
);

  localparam int unsigned       N_VEC    = 2**N_IN;
  localparam logic [N_IN-1:0]   VEC_LAST = {N_IN{1'b1}};

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              load_c;
  logic              settle_expire_c;
  logic              mismatch_c;
`ifdef GATE_TT_CAPTURE_EN
  logic [N_VEC-1:0]  obs_q, obs_d;
`endif

  // Settle-time counter runs only while a vector is being driven
  gate_tt_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .en       (state_q == DRIVE),
    .expire_c (settle_expire_c)
  );

  assign mismatch_c = (y_in != EXP_TT[vec_q]);

  // Next-state and scoreboard update
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    load_c  = 1'b0;
`ifdef GATE_TT_CAPTURE_EN
    obs_d   = obs_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          load_c  = 1'b1;
`ifdef GATE_TT_CAPTURE_EN
          obs_d   = '0;
`endif
        end
      end
      DRIVE: begin
        if (settle_expire_c) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch_c) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            first_d = vec_q;
          end
        end
`ifdef GATE_TT_CAPTURE_EN
        obs_d[vec_q] = y_in;
`endif
        if (vec_q == VEC_LAST) begin
          // Pass uses the updated count so a last-vector mismatch is included
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + 1'b1;
          load_c  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GATE_TT_CAPTURE_EN
  // Captured response table
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      obs_q <= '0;
    end else begin
      obs_q <= obs_d;
    end
  end

  assign observed_tt = obs_q;
`endif

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_vec = first_q;

endmodule
